// File: rtl/common_reset_sequencer_if.sv
// Interface bundling the lock/request inputs and the sequenced reset
// outputs of common_reset_sequencer. The sequencer connects through the
// slave modport and the surrounding logic connects through the master modport.
interface common_reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);

  logic                  i_pll_locked;
  logic                  i_sw_rst;
  logic [NUM_STAGES-1:0] o_srst;
  logic                  o_done;
  logic                  o_lock_timeout;

  modport master (
    output i_pll_locked,
    output i_sw_rst,
    input  o_srst,
    input  o_done,
    input  o_lock_timeout
  );

  modport slave (
    input  i_pll_locked,
    input  i_sw_rst,
    output o_srst,
    output o_done,
    output o_lock_timeout
  );

endinterface

// File: rtl/common_reset_sequencer.sv
// common_reset_sequencer: takes the synchronised reset and PLL lock, holds
// every domain in reset for a minimum time, waits for a stable lock, then
// releases the NUM_STAGES reset domains in ascending order, STAGE_DELAY
// cycles apart. A software request or lock loss throws every domain back
// into reset.
// Optional lock-wait watchdog: define COMMON_RESET_SEQ_WDT_EN. Without it
// o_lock_timeout is tied low and no watchdog logic exists.
module common_reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOCK_CYCLES    = 64,
  parameter int STAGE_DELAY    = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  common_reset_sequencer_if.slave  bus
);

  // Elaboration-time sanity check on the configuration.
  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || LOCK_CYCLES < 1 ||
      STAGE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_badParams
    $error("common_reset_sequencer: all parameters must be >= 1");
  end

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);
  localparam int STAGE_W = $clog2(STAGE_DELAY + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);

  localparam logic [1:0] ST_HOLD      = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]            state_q,      state_d;
  logic [HOLD_W-1:0]     holdCount_q,  holdCount_d;
  logic [LOCK_W-1:0]     lockCount_q,  lockCount_d;
  logic [STAGE_W-1:0]    stageCount_q, stageCount_d;
  logic [NUM_STAGES-1:0] srst_q,       srst_d;
  logic                  done_q,       done_d;

  // Releasing one more stage is a left shift with zero fill: bit 0 drops
  // first and no bit can ever clear ahead of a lower-index bit.
  logic [NUM_STAGES-1:0] srstShift;
  logic                  restartReq;

  assign srstShift  = srst_q << 1;
  assign restartReq = bus.i_sw_rst ||
                      (((state_q == ST_RELEASE) || (state_q == ST_DONE)) &&
                       !bus.i_pll_locked);

  // Next-state logic: restart requests win, otherwise advance hold, lock
  // qualification and the staged release.
  always_comb begin
    state_d      = state_q;
    holdCount_d  = holdCount_q;
    lockCount_d  = lockCount_q;
    stageCount_d = stageCount_q;
    srst_d       = srst_q;
    done_d       = done_q;

    if (restartReq) begin
      state_d      = ST_HOLD;
      holdCount_d  = '0;
      lockCount_d  = '0;
      stageCount_d = '0;
      srst_d       = '1;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (holdCount_q == HOLD_LAST) begin
            state_d     = ST_WAIT_LOCK;
            holdCount_d = '0;
            lockCount_d = '0;
          end else begin
            holdCount_d = holdCount_q + HOLD_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (!bus.i_pll_locked) begin
            lockCount_d = '0;
          end else if (lockCount_q == LOCK_LAST) begin
            lockCount_d  = '0;
            stageCount_d = '0;
            srst_d       = srstShift;
            if (srstShift == '0) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            lockCount_d = lockCount_q + LOCK_W'(1);
          end
        end

        ST_RELEASE: begin
          if (stageCount_q == STAGE_LAST) begin
            stageCount_d = '0;
            srst_d       = srstShift;
            if (srstShift == '0) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            stageCount_d = stageCount_q + STAGE_W'(1);
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d      = ST_HOLD;
          holdCount_d  = '0;
          lockCount_d  = '0;
          stageCount_d = '0;
          srst_d       = '1;
          done_d       = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; the incoming reset forces the full-reset state.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q      <= ST_HOLD;
      holdCount_q  <= '0;
      lockCount_q  <= '0;
      stageCount_q <= '0;
      srst_q       <= '1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      holdCount_q  <= holdCount_d;
      lockCount_q  <= lockCount_d;
      stageCount_q <= stageCount_d;
      srst_q       <= srst_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_srst = srst_q;
  assign bus.o_done = done_q;

`ifdef COMMON_RESET_SEQ_WDT_EN
  localparam int WDT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(TIMEOUT_CYCLES);

  logic [WDT_W-1:0] wdtCount_q, wdtCount_d;
  logic             timeout_q,  timeout_d;

  // Watchdog next state: counts every WAIT_LOCK cycle regardless of lock
  // toggling, saturates at the limit, and the flag only clears on a full reset.
  always_comb begin
    wdtCount_d = wdtCount_q;
    timeout_d  = timeout_q;
    if (bus.i_sw_rst) begin
      wdtCount_d = '0;
      timeout_d  = 1'b0;
    end else if (restartReq || (state_q == ST_HOLD)) begin
      wdtCount_d = '0;
    end else if (state_q == ST_WAIT_LOCK) begin
      if (wdtCount_q != WDT_LIMIT) begin
        wdtCount_d = wdtCount_q + WDT_W'(1);
      end
      if (wdtCount_q == WDT_LIMIT - WDT_W'(1)) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wdtCount_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdtCount_q <= wdtCount_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_lock_timeout = timeout_q;
`else
  assign bus.o_lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_common_reset_sequencer.sv
// Testbench for common_reset_sequencer. Expected output snapshots are
// derived from the documented release latencies, queued when the stimulus
// of a scenario is driven, and compared when the DUT reaches that edge.
// Two DUTs: the default 4-stage configuration and a minimal 1-stage one.
// Define COMMON_RESET_SEQ_WDT_EN to also exercise the lock watchdog.
module tb_common_reset_sequencer;

  typedef struct {
    int         unitSel;
    int         edgeIdx;
    logic [3:0] srst;
    logic       done;
    logic       tmo;
    string      tag;
  } exp_t;

  logic clk;
  logic srstMain;
  logic srstOne;

  common_reset_sequencer_if #(.NUM_STAGES(4)) busMain ();
  common_reset_sequencer_if #(.NUM_STAGES(1)) busOne ();

  common_reset_sequencer #(
    .NUM_STAGES(4), .HOLD_CYCLES(16), .LOCK_CYCLES(64),
    .STAGE_DELAY(8), .TIMEOUT_CYCLES(100)
  ) dutMain (
    .i_clk (clk),
    .i_srst(srstMain),
    .bus   (busMain)
  );

  common_reset_sequencer #(
    .NUM_STAGES(1), .HOLD_CYCLES(1), .LOCK_CYCLES(1),
    .STAGE_DELAY(1), .TIMEOUT_CYCLES(65536)
  ) dutOne (
    .i_clk (clk),
    .i_srst(srstOne),
    .bus   (busOne)
  );

  exp_t sbQ[$];
  int   checks;
  int   errors;
  int   edgeNum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)",
               tag, observed, expected, edgeNum);
    end
  endtask

  // Drive the inputs of the 4-stage DUT for the next edge.
  task automatic applyStimulus(input logic srstV, input logic lockV,
                               input logic swV);
    srstMain             = srstV;
    busMain.i_pll_locked = lockV;
    busMain.i_sw_rst     = swV;
  endtask

  task automatic expectAt(input int unitSel, input int e, input logic [3:0] s,
                          input logic d, input logic t, input string tag);
    exp_t item;
    item.unitSel = unitSel;
    item.edgeIdx = e;
    item.srst    = s;
    item.done    = d;
    item.tmo     = t;
    item.tag     = tag;
    sbQ.push_back(item);
  endtask

  // Advance one edge, sample 1 time unit later, check invariants and any
  // scoreboard entries due at this edge.
  task automatic stepCycle();
    exp_t       item;
    logic [3:0] rel;
    @(posedge clk);
    #1;
    edgeNum++;
    rel = ~busMain.o_srst;
    checkOutput("monotonic", {28'd0, rel & (rel + 4'd1)}, 32'd0);
`ifndef COMMON_RESET_SEQ_WDT_EN
    checkOutput("tmoTied", {31'd0, busMain.o_lock_timeout}, 32'd0);
`endif
    while (sbQ.size() > 0 && sbQ[0].edgeIdx <= edgeNum) begin
      item = sbQ.pop_front();
      if (item.edgeIdx < edgeNum) begin
        checkOutput({item.tag, "_missed"}, edgeNum, item.edgeIdx);
      end else if (item.unitSel == 0) begin
        checkOutput({item.tag, "_srst"}, {28'd0, busMain.o_srst}, {28'd0, item.srst});
        checkOutput({item.tag, "_done"}, {31'd0, busMain.o_done}, {31'd0, item.done});
        checkOutput({item.tag, "_tmo"}, {31'd0, busMain.o_lock_timeout}, {31'd0, item.tmo});
      end else begin
        checkOutput({item.tag, "_srst"}, {31'd0, busOne.o_srst}, {28'd0, item.srst});
        checkOutput({item.tag, "_done"}, {31'd0, busOne.o_done}, {31'd0, item.done});
        checkOutput({item.tag, "_tmo"}, {31'd0, busOne.o_lock_timeout}, {31'd0, item.tmo});
      end
    end
  endtask

  // Any entry left after a scenario was never reached: count it as failed.
  task automatic drainLeftovers();
    exp_t item;
    while (sbQ.size() > 0) begin
      item = sbQ.pop_front();
      checkOutput({item.tag, "_notReached"}, edgeNum, item.edgeIdx);
    end
  endtask

  // Reset the selected unit at edge e0 (checking the reset state), then
  // release the reset so e1 is the first edge sampling it low.
  task automatic startScenario(input int unitSel, input string tag);
    edgeNum = -1;
    if (unitSel == 0) begin
      expectAt(0, 0, 4'b1111, 1'b0, 1'b0, {tag, "_reset"});
      srstMain = 1'b1;
    end else begin
      expectAt(1, 0, 4'b0001, 1'b0, 1'b0, {tag, "_reset"});
      srstOne = 1'b1;
    end
    stepCycle();
    srstMain = 1'b0;
    srstOne  = (unitSel == 1) ? 1'b0 : srstOne;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    edgeNum = -1;
    srstMain = 1'b1;
    srstOne  = 1'b1;
    busMain.i_pll_locked = 1'b1;
    busMain.i_sw_rst     = 1'b0;
    busOne.i_pll_locked  = 1'b1;
    busOne.i_sw_rst      = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal release with lock held high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    startScenario(0, "t1");
    expectAt(0, 16,  4'b1111, 1'b0, 1'b0, "t1_e16");
    expectAt(0, 79,  4'b1111, 1'b0, 1'b0, "t1_e79");
    expectAt(0, 80,  4'b1110, 1'b0, 1'b0, "t1_e80");
    expectAt(0, 87,  4'b1110, 1'b0, 1'b0, "t1_e87");
    expectAt(0, 88,  4'b1100, 1'b0, 1'b0, "t1_e88");
    expectAt(0, 95,  4'b1100, 1'b0, 1'b0, "t1_e95");
    expectAt(0, 96,  4'b1000, 1'b0, 1'b0, "t1_e96");
    expectAt(0, 103, 4'b1000, 1'b0, 1'b0, "t1_e103");
    expectAt(0, 104, 4'b0000, 1'b1, 1'b0, "t1_e104");
    expectAt(0, 110, 4'b0000, 1'b1, 1'b0, "t1_e110");
    while (edgeNum < 112) stepCycle();
    drainLeftovers();

    // One unlocked sample at e50 restarts lock qualification.
    applyStimulus(1'b1, 1'b1, 1'b0);
    startScenario(0, "t2");
    expectAt(0, 49,  4'b1111, 1'b0, 1'b0, "t2_e49");
    expectAt(0, 113, 4'b1111, 1'b0, 1'b0, "t2_e113");
    expectAt(0, 114, 4'b1110, 1'b0, 1'b0, "t2_e114");
    expectAt(0, 138, 4'b0000, 1'b1, 1'b0, "t2_e138");
    while (edgeNum < 140) begin
      if (edgeNum == 49) applyStimulus(1'b0, 1'b0, 1'b0);
      if (edgeNum == 50) applyStimulus(1'b0, 1'b1, 1'b0);
      stepCycle();
    end
    drainLeftovers();

    // Lock lost for one sample (edge e91) with two stages released.
    applyStimulus(1'b1, 1'b1, 1'b0);
    startScenario(0, "t3");
    expectAt(0, 88,  4'b1100, 1'b0, 1'b0, "t3_e88");
    expectAt(0, 90,  4'b1100, 1'b0, 1'b0, "t3_e90");
    expectAt(0, 91,  4'b1111, 1'b0, 1'b0, "t3_e91");
    expectAt(0, 170, 4'b1111, 1'b0, 1'b0, "t3_e170");
    expectAt(0, 171, 4'b1110, 1'b0, 1'b0, "t3_e171");
    expectAt(0, 195, 4'b0000, 1'b1, 1'b0, "t3_e195");
    while (edgeNum < 198) begin
      if (edgeNum == 90) applyStimulus(1'b0, 1'b0, 1'b0);
      if (edgeNum == 91) applyStimulus(1'b0, 1'b1, 1'b0);
      stepCycle();
    end
    drainLeftovers();

    // Software request held for five edges in DONE, then i_srst mid-release.
    applyStimulus(1'b1, 1'b1, 1'b0);
    startScenario(0, "t4");
    expectAt(0, 104, 4'b0000, 1'b1, 1'b0, "t4_e104");
    expectAt(0, 111, 4'b1111, 1'b0, 1'b0, "t4_e111");
    expectAt(0, 115, 4'b1111, 1'b0, 1'b0, "t4_e115");
    expectAt(0, 194, 4'b1111, 1'b0, 1'b0, "t4_e194");
    expectAt(0, 195, 4'b1110, 1'b0, 1'b0, "t4_e195");
    expectAt(0, 200, 4'b1110, 1'b0, 1'b0, "t4_e200");
    expectAt(0, 201, 4'b1111, 1'b0, 1'b0, "t4_e201");
    expectAt(0, 280, 4'b1111, 1'b0, 1'b0, "t4_e280");
    expectAt(0, 281, 4'b1110, 1'b0, 1'b0, "t4_e281");
    while (edgeNum < 283) begin
      if (edgeNum == 110) applyStimulus(1'b0, 1'b1, 1'b1);
      if (edgeNum == 115) applyStimulus(1'b0, 1'b1, 1'b0);
      if (edgeNum == 200) applyStimulus(1'b1, 1'b1, 1'b0);
      if (edgeNum == 201) applyStimulus(1'b0, 1'b1, 1'b0);
      stepCycle();
    end
    drainLeftovers();

    // Minimal configuration: one stage, single-cycle hold and lock.
    applyStimulus(1'b1, 1'b1, 1'b0);
    busOne.i_pll_locked = 1'b1;
    startScenario(1, "t5");
    expectAt(1, 1, 4'b0001, 1'b0, 1'b0, "t5_e1");
    expectAt(1, 2, 4'b0000, 1'b1, 1'b0, "t5_e2");
    expectAt(1, 4, 4'b0000, 1'b1, 1'b0, "t5_e4");
    expectAt(1, 5, 4'b0001, 1'b0, 1'b0, "t5_e5");
    expectAt(1, 6, 4'b0001, 1'b0, 1'b0, "t5_e6");
    expectAt(1, 7, 4'b0000, 1'b1, 1'b0, "t5_e7");
    expectAt(1, 9, 4'b0000, 1'b1, 1'b0, "t5_e9");
    while (edgeNum < 10) begin
      if (edgeNum == 4) busOne.i_pll_locked = 1'b0;
      if (edgeNum == 5) busOne.i_pll_locked = 1'b1;
      stepCycle();
    end
    drainLeftovers();

`ifdef COMMON_RESET_SEQ_WDT_EN
    // Watchdog: 100 WAIT_LOCK edges without lock, flag survives release and
    // lock loss, cleared by the software request.
    applyStimulus(1'b1, 1'b0, 1'b0);
    startScenario(0, "t6");
    expectAt(0, 115, 4'b1111, 1'b0, 1'b0, "t6_e115");
    expectAt(0, 116, 4'b1111, 1'b0, 1'b1, "t6_e116");
    expectAt(0, 129, 4'b1111, 1'b0, 1'b1, "t6_e129");
    expectAt(0, 192, 4'b1111, 1'b0, 1'b1, "t6_e192");
    expectAt(0, 193, 4'b1110, 1'b0, 1'b1, "t6_e193");
    expectAt(0, 217, 4'b0000, 1'b1, 1'b1, "t6_e217");
    expectAt(0, 221, 4'b1111, 1'b0, 1'b1, "t6_e221");
    expectAt(0, 226, 4'b1111, 1'b0, 1'b0, "t6_e226");
    while (edgeNum < 230) begin
      if (edgeNum == 129) applyStimulus(1'b0, 1'b1, 1'b0);
      if (edgeNum == 220) applyStimulus(1'b0, 1'b0, 1'b0);
      if (edgeNum == 221) applyStimulus(1'b0, 1'b1, 1'b0);
      if (edgeNum == 225) applyStimulus(1'b0, 1'b1, 1'b1);
      if (edgeNum == 226) applyStimulus(1'b0, 1'b1, 1'b0);
      stepCycle();
    end
    drainLeftovers();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
